// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, sizes and byte-level helpers (S-box, xtime).
package aes_pkg;

   localparam int NR      = 10;
   localparam int IDX_W   = 4;
   localparam int KEY_W   = 128;
   localparam int WORD_W  = 32;
   localparam int SCHED_W = 1408;

   typedef logic [KEY_W-1:0]  rk_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } ks_state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_subword
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_word
);

   for (genvar gb = 0; gb < 4; gb++) begin : g_byte
      assign o_word[8*gb +: 8] = sbox(i_word[8*gb +: 8]);
   end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry buffer,
// streamed as produced and readable by index. AES_KS_FLAT_OUT_EN adds the flat o_key_flat bus.
//
// state     | meaning
// ST_IDLE   | no schedule yet (or after reset); waits for i_start
// ST_EXPAND | computing rk[r_round] from previous key, one per clock
// ST_DONE   | rk0..rk10 complete, keys_valid held; i_start restarts
module aes_key_expand_seq
   import aes_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [KEY_W-1:0]   i_key,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_keys_valid,
   output logic               o_rk_valid,
   output logic [IDX_W-1:0]   o_rk_idx,
   output logic [KEY_W-1:0]   o_rk_data,
   input  logic [IDX_W-1:0]   i_rd_idx,
   output logic [KEY_W-1:0]   o_rd_key
`ifdef AES_KS_FLAT_OUT_EN
   ,
   output logic [SCHED_W-1:0] o_key_flat
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

   ks_state_t        r_state;
   logic [7:0]       r_rcon;
   logic [IDX_W-1:0] r_round;
   rk_t              r_cur;
   rk_t              r_buf [0:NR];

   word_t            w_rot;
   word_t            w_sub;
   word_t            w_t;
   rk_t              w_next;
   logic             w_load;
   logic             w_step;

   assign w_rot = {r_cur[103:96], r_cur[127:104]};

   aes_subword u_subword (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   assign w_t          = w_sub ^ {24'b0, r_rcon};
   assign w_next[31:0]  = r_cur[31:0]   ^ w_t;
   assign w_next[63:32] = r_cur[63:32]  ^ w_next[31:0];
   assign w_next[95:64] = r_cur[95:64]  ^ w_next[63:32];
   assign w_next[127:96] = r_cur[127:96] ^ w_next[95:64];

   assign w_load = !i_rst && i_start && (r_state != ST_EXPAND);
   assign w_step = !i_rst && (r_state == ST_EXPAND);

   // Key storage is deliberately not reset; reads after reset return stale keys.
   always_ff @(posedge i_clk) begin
      if (w_load) begin
         r_buf[0] <= i_key;
         r_cur    <= i_key;
      end else if (w_step) begin
         r_buf[r_round] <= w_next;
         r_cur          <= w_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_rcon       <= 8'h01;
         r_round      <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_keys_valid <= 1'b0;
         o_rk_valid   <= 1'b0;
         o_rk_idx     <= '0;
         o_rk_data    <= '0;
         o_rd_key     <= '0;
      end else begin
         o_done     <= 1'b0;
         o_rk_valid <= 1'b0;
         o_rd_key   <= (i_rd_idx <= LAST_IDX) ? r_buf[i_rd_idx] : '0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  r_state      <= ST_EXPAND;
                  r_rcon       <= 8'h01;
                  r_round      <= 4'd1;
                  o_keys_valid <= 1'b0;
                  o_busy       <= 1'b1;
               end
            end
            ST_EXPAND: begin
               o_rk_valid <= 1'b1;
               o_rk_idx   <= r_round;
               o_rk_data  <= w_next;
               r_round    <= r_round + 1'b1;
               r_rcon     <= xtime(r_rcon);
               if (r_round == LAST_IDX) begin
                  r_state      <= ST_DONE;
                  o_done       <= 1'b1;
                  o_keys_valid <= 1'b1;
                  o_busy       <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef AES_KS_FLAT_OUT_EN
   for (genvar gi = 0; gi <= NR; gi++) begin : g_flat
      assign o_key_flat[KEY_W*gi +: KEY_W] = r_buf[gi];
   end
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq: FIPS-197 and all-zero key schedules, ignored restart,
// mid-expansion reset and indexed read-back, with a scoreboard on the round-key stream.
module tb_aes_key_expand_seq;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [127:0]  key;
   logic          busy, done, keys_valid, rk_valid;
   logic [3:0]    rk_idx;
   logic [127:0]  rk_data;
   logic [3:0]    rd_idx;
   logic [127:0]  rd_key;
`ifdef AES_KS_FLAT_OUT_EN
   logic [1407:0] key_flat;
`endif

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] data;
      bit           chk;
   } exp_t;

   exp_t         sb_q[$];
   logic [127:0] rd_q[$];

   // FIPS-197 appendix A.1 round keys, written as byte strings (first byte leftmost)
   localparam logic [127:0] FIPS_BS [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   localparam logic [127:0] ZERO_RK1_BS  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10_BS = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] ALT_BS       = 128'h000102030405060708090a0b0c0d0e0f;

   aes_key_expand_seq dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_key        (key),
      .o_busy       (busy),
      .o_done       (done),
      .o_keys_valid (keys_valid),
      .o_rk_valid   (rk_valid),
      .o_rk_idx     (rk_idx),
      .o_rk_data    (rk_data),
      .i_rd_idx     (rd_idx),
      .o_rd_key     (rd_key)
`ifdef AES_KS_FLAT_OUT_EN
      ,
      .o_key_flat   (key_flat)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] bs2k(input logic [127:0] bs);
      logic [127:0] k;
      for (int i = 0; i < 16; i++) k[8*i +: 8] = bs[127-8*i -: 8];
      return k;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stream(input logic [127:0] bs_tab [0:10], input int last);
      for (int i = 1; i <= last; i++) sb_q.push_back('{idx: 4'(i), data: bs2k(bs_tab[i]), chk: 1'b1});
   endtask

   // Stream monitor: every rk_valid strobe must match the next scoreboard entry
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (rk_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL stream_unexpected observed idx=%0d data=%h expected no strobe", rk_idx, rk_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("stream_idx", {124'b0, rk_idx}, {124'b0, e.idx});
            if (e.chk) chk("stream_data", rk_data, e.data);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int waited;
      logic [127:0] zero_tab [0:10];
      rst = 1'b1; start = 1'b0; key = '0; rd_idx = '0;
      repeat (3) tick();
      chk("rst_busy", {127'b0, busy}, 128'd0);
      chk("rst_done", {127'b0, done}, 128'd0);
      chk("rst_keys_valid", {127'b0, keys_valid}, 128'd0);
      chk("rst_rk_valid", {127'b0, rk_valid}, 128'd0);
      chk("rst_rk_idx", {124'b0, rk_idx}, 128'd0);
      chk("rst_rk_data", rk_data, 128'd0);
      chk("rst_rd_key", rd_key, 128'd0);
      rst = 1'b0;
      tick();

      // FIPS key, with a second start (different key) at T+4 that must be ignored
      push_stream(FIPS_BS, 10);
      key = bs2k(FIPS_BS[0]);
      start = 1'b1;
      base = done_cnt;
      tick();
      start = 1'b0;
      chk("fips_busy_T", {127'b0, busy}, 128'd1);
      for (int c = 1; c <= 10; c++) begin
         if (c == 4) begin
            start = 1'b1;
            key = bs2k(ALT_BS);
         end
         tick();
         start = 1'b0;
         if (c <= 9) chk($sformatf("fips_busy_T%0d", c), {127'b0, busy}, 128'd1);
      end
      chk("fips_done_T10", {127'b0, done}, 128'd1);
      chk("fips_kv_T10", {127'b0, keys_valid}, 128'd1);
      chk("fips_busy_T10", {127'b0, busy}, 128'd0);
      chk("fips_rk10", rk_data, bs2k(FIPS_BS[10]));
      tick();
      chk("fips_done_pulse", {127'b0, done}, 128'd0);
      chk("fips_kv_hold", {127'b0, keys_valid}, 128'd1);
      chk("fips_rk_valid_done", {127'b0, rk_valid}, 128'd0);
      chk("fips_done_count", 128'(done_cnt - base), 128'd1);
      chk("fips_stream_drained", 128'(sb_q.size()), 128'd0);

      // Back-to-back index sweep, one-cycle read latency
      for (int i = 0; i <= 15; i++) rd_q.push_back(i <= 10 ? bs2k(FIPS_BS[i]) : 128'd0);
      for (int i = 0; i <= 15; i++) begin
         rd_idx = 4'(i);
         tick();
         chk($sformatf("rd_sweep_%0d", i), rd_key, rd_q.pop_front());
`ifdef AES_KS_FLAT_OUT_EN
         if (i <= 10) chk($sformatf("flat_%0d", i), key_flat[128*i +: 128], bs2k(FIPS_BS[i]));
`endif
      end

      // All-zero key; read of index 1 while rk1 is written sees the old key first
      zero_tab = FIPS_BS;
      zero_tab[1] = ZERO_RK1_BS;
      zero_tab[10] = ZERO_RK10_BS;
      for (int i = 1; i <= 10; i++)
         sb_q.push_back('{idx: 4'(i), data: bs2k(zero_tab[i]), chk: (i == 1 || i == 10)});
      rd_idx = 4'd1;
      key = '0;
      start = 1'b1;
      base = done_cnt;
      tick();
      start = 1'b0;
      chk("zero_kv_cleared", {127'b0, keys_valid}, 128'd0);
      tick();
      chk("rd_same_cycle_old", rd_key, bs2k(FIPS_BS[1]));
      tick();
      chk("rd_next_cycle_new", rd_key, bs2k(ZERO_RK1_BS));
      repeat (8) tick();
      chk("zero_done_T10", {127'b0, done}, 128'd1);
      chk("zero_rk10", rk_data, bs2k(ZERO_RK10_BS));
      rd_idx = 4'd0;
      tick();
      chk("zero_rd0", rd_key, 128'd0);
      rd_idx = 4'd11;
      tick();
      chk("zero_rd11", rd_key, 128'd0);
      rd_idx = 4'd10;
      tick();
      chk("zero_rd10", rd_key, bs2k(ZERO_RK10_BS));
      chk("zero_done_count", 128'(done_cnt - base), 128'd1);

      // Reset at T+5 aborts the expansion with no done pulse
      push_stream(FIPS_BS, 4);
      key = bs2k(FIPS_BS[0]);
      start = 1'b1;
      base = done_cnt;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", {127'b0, busy}, 128'd0);
      chk("abort_rk_valid", {127'b0, rk_valid}, 128'd0);
      chk("abort_kv", {127'b0, keys_valid}, 128'd0);
      chk("abort_rk_idx", {124'b0, rk_idx}, 128'd0);
      rst = 1'b0;
      repeat (12) tick();
      chk("abort_no_done", 128'(done_cnt - base), 128'd0);
      chk("abort_stream_drained", 128'(sb_q.size()), 128'd0);

      // Fresh start after the abort yields the full schedule
      push_stream(FIPS_BS, 10);
      start = 1'b1;
      base = done_cnt;
      tick();
      start = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      chk("restart_latency", 128'(waited), 128'd10);
      chk("restart_kv", {127'b0, keys_valid}, 128'd1);
      rd_idx = 4'd5;
      tick();
      chk("restart_rd5", rd_key, bs2k(FIPS_BS[5]));
      chk("restart_stream_drained", 128'(sb_q.size()), 128'd0);
      chk("restart_done_count", 128'(done_cnt - base), 128'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
